// File: rtl/loader_pkg.sv
// loader_pkg: shared FSM states, sync bytes and error encodings for the program loader
package loader_pkg;

    typedef enum logic [2:0] {
        SYNC0,
        SYNC1,
        CNT0,
        CNT1,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam logic [7:0] SYNC_BYTE0 = 8'hA5;
    localparam logic [7:0] SYNC_BYTE1 = 8'h5A;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_CSUM = 2'b10;

endpackage

// File: rtl/loader_word_assembler.sv
// loader_word_assembler: packs payload bytes LSB-first into 32-bit words and keeps the running XOR
module loader_word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        word_valid,
    output logic [31:0] word,
    output logic [7:0]  csum
);

    logic [1:0]  byte_idx;
    logic [23:0] lanes;

    // The fourth byte completes the word combinationally so the top can register it in one step.
    assign word_valid = in_valid && byte_idx == 2'd3;
    assign word       = {in_data, lanes};

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            byte_idx <= '0;
            lanes    <= '0;
            csum     <= '0;
        end else if (in_valid) begin
            byte_idx <= byte_idx + 2'd1;
            lanes    <= {in_data, lanes[23:8]};
            csum     <= csum ^ in_data;
        end
    end

endmodule

// File: rtl/imem_program_loader.sv
// imem_program_loader: framed byte-stream loader writing verified words into instruction memory
module imem_program_loader
    import loader_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_waddr,
    output logic [31:0] imem_wdata,
    output logic        loader_done,
    output logic        load_error,
    output logic [1:0]  err_code,
    output logic [15:0] words_loaded
);

    state_t      state, state_next;
    logic        accept;
    logic        clear;
    logic        asm_valid;
    logic        word_valid;
    logic [31:0] word;
    logic [7:0]  csum;
    logic [7:0]  cnt_lo;
    logic [15:0] frame_words;
    logic [15:0] n_next;
    logic        len_bad;
    logic [1:0]  err_next;

    assign rx_ready    = state != DONE && state != ERR;
    assign accept      = rx_valid && rx_ready;
    assign loader_done = state == DONE;
    assign load_error  = state == ERR;
    assign n_next      = {rx_data, cnt_lo};
    assign len_bad     = n_next == 16'd0 || 32'(n_next) > 32'(IMEM_DEPTH_WORDS);
    assign asm_valid   = accept && state == DATA;

    loader_word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .in_valid   (asm_valid),
        .in_data    (rx_data),
        .word_valid (word_valid),
        .word       (word),
        .csum       (csum)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= SYNC0;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        clear      = 1'b0;
        err_next   = err_code;
        case (state)
            SYNC0: state_next = accept && rx_data == SYNC_BYTE0 ? SYNC1 : SYNC0;
            SYNC1: if (accept)
                state_next = rx_data == SYNC_BYTE1 ? CNT0 : rx_data == SYNC_BYTE0 ? SYNC1 : SYNC0;
            CNT0: state_next = accept ? CNT1 : CNT0;
            CNT1: if (accept) begin
                state_next = len_bad ? ERR : DATA;
                err_next   = len_bad ? ERR_LEN : ERR_NONE;
                clear      = !len_bad;
            end
            DATA: state_next = word_valid && words_loaded == frame_words - 16'd1 ? CSUM : DATA;
            CSUM: if (accept) begin
                state_next = rx_data == csum ? DONE : ERR;
                err_next   = rx_data == csum ? ERR_NONE : ERR_CSUM;
            end
            default: state_next = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_lo       <= '0;
            frame_words  <= '0;
            imem_we      <= 1'b0;
            imem_waddr   <= BASE_ADDR;
            imem_wdata   <= '0;
            words_loaded <= '0;
            err_code     <= ERR_NONE;
        end else begin
            imem_we  <= word_valid;
            err_code <= err_next;
            if (accept && state == CNT0)
                cnt_lo <= rx_data;
            if (accept && state == CNT1)
                frame_words <= n_next;
            if (clear)
                words_loaded <= '0;
            // words_loaded doubles as the word index; the address wraps modulo 2^32.
            if (word_valid) begin
                imem_wdata   <= word;
                imem_waddr   <= BASE_ADDR + {14'd0, words_loaded, 2'b00};
                words_loaded <= words_loaded + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_imem_program_loader.sv
// tb_imem_program_loader: randomized framed-stream stimulus with a write scoreboard and frame-level reference model
module tb_imem_program_loader;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic        loader_done;
    logic        load_error;
    logic [1:0]  err_code;
    logic [15:0] words_loaded;

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];
    logic [31:0] payload[$];
    logic [63:0] mon_e;

    imem_program_loader #(.IMEM_DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .imem_we      (imem_we),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata),
        .loader_done  (loader_done),
        .load_error   (load_error),
        .err_code     (err_code),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (!rst && imem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=%h:%h required=none", imem_waddr, imem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("write_addr", imem_waddr, mon_e[63:32]);
                chk("write_data", imem_wdata, mon_e[31:0]);
            end
        end
    end

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rx_ready", 32'(rx_ready), 32'd1);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_waddr", imem_waddr, BASE);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_flags", {28'd0, loader_done, load_error, err_code}, 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        repeat ($urandom_range(maxgap, 0)) @(negedge clk);
        rx_valid = 1'b1;
        rx_data = b;
        chk("rx_ready", 32'(rx_ready), 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data = $urandom;
    endtask

    // Reference model: a frame either fails length, or writes every word then passes or fails its XOR.
    task automatic run_frame(input logic [15:0] n, input bit bad_csum, input int maxgap, input bit junk);
        logic [7:0] x;
        logic [7:0] cs;
        bit len_bad;
        x = 8'h00;
        len_bad = n == 16'd0 || 32'(n) > DEPTH;
        if (junk) begin
            send_byte(8'h00, maxgap);
            send_byte(8'hA5, maxgap);
        end
        send_byte(8'hA5, maxgap);
        send_byte(8'h5A, maxgap);
        send_byte(n[7:0], maxgap);
        send_byte(n[15:8], maxgap);
        if (!len_bad) begin
            for (int i = 0; i < int'(n); i++) begin
                logic [31:0] w;
                w = payload[i];
                exp_q.push_back({BASE + 32'(i) * 32'd4, w});
                for (int k = 0; k < 4; k++) begin
                    send_byte(w[8*k +: 8], maxgap);
                    x = x ^ w[8*k +: 8];
                end
            end
            cs = bad_csum ? x ^ 8'($urandom_range(255, 1)) : x;
            send_byte(cs, maxgap);
        end
        repeat (3) @(negedge clk);
        chk("writes_drained", exp_q.size(), 32'd0);
        chk("loader_done", 32'(loader_done), 32'(!len_bad && !bad_csum));
        chk("load_error", 32'(load_error), 32'(len_bad || bad_csum));
        chk("err_code", 32'(err_code), len_bad ? 32'd1 : bad_csum ? 32'd2 : 32'd0);
        chk("words_loaded", 32'(words_loaded), len_bad ? 32'd0 : 32'(n));
        chk("rx_ready_end", 32'(rx_ready), 32'd0);
        chk("we_idle", 32'(imem_we), 32'd0);
    endtask

    task automatic fill_random(input int n);
        payload.delete();
        repeat (n) payload.push_back($urandom);
    endtask

    initial begin
        reset_dut();
        payload = '{32'h0000_0013, 32'h0010_0093};
        run_frame(16'd2, 1'b0, 0, 1'b0);

        reset_dut();
        run_frame(16'd2, 1'b1, 0, 1'b0);

        reset_dut();
        run_frame(16'd0, 1'b0, 0, 1'b0);
        reset_dut();
        run_frame(16'(DEPTH + 1), 1'b0, 0, 1'b0);

        reset_dut();
        fill_random(1);
        run_frame(16'd1, 1'b0, 0, 1'b1);

        reset_dut();
        payload = '{32'h0000_0013, 32'h0010_0093};
        run_frame(16'd2, 1'b0, 5, 1'b0);

        // Abort mid-frame: one full word written, then two bytes of the next word.
        reset_dut();
        fill_random(3);
        send_byte(8'hA5, 0);
        send_byte(8'h5A, 0);
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        exp_q.push_back({BASE, payload[0]});
        for (int k = 0; k < 4; k++) send_byte(payload[0][8*k +: 8], 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        chk("partial_write", exp_q.size(), 32'd0);
        chk("partial_words", 32'(words_loaded), 32'd1);
        reset_dut();
        fill_random(3);
        run_frame(16'd3, 1'b0, 0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(8, 1);
            reset_dut();
            fill_random(n);
            run_frame(16'(n), ($urandom % 3) == 0, $urandom_range(3, 0), r[0]);
        end

        reset_dut();
        fill_random(DEPTH);
        run_frame(16'(DEPTH), 1'b0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
